// File: rtl/regfile_pkg.sv
// Purpose: shared constants and helpers for the 2-read/1-write register file.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH : default entry width and address width
//   depth_of()                      : number of entries for a given address width
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;

  // Depth of a register file addressed by aw bits.
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage : regfile_pkg

// File: rtl/regfile_2r1w_cell.sv
// Purpose: one storage entry of the register file (enabled register, loadable reset value).
// Latency: 1 cycle from d/en to q.
// Backpressure: none; a write with en=1 is always taken unless reset is high.
//
// Ports:
//   Clk     : clock, rising edge
//   reset   : synchronous active-high reset, wins over en
//   en      : load enable
//   rst_val : value loaded on reset
//   d       : data to load
//   q       : stored value
module reg_cell
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] rst_val,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge Clk) begin
    if (reset) begin
      q <= rst_val;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : reg_cell

// File: rtl/regfile_2r1w.sv
// Purpose: 2^ADDR_WIDTH x DATA_WIDTH register file, 1 sync write, 2 async reads, optional bypass / zero entry.
// Latency: write 1 cycle (0 via bypass); reads combinational.
// Backpressure: none; every write with we=1 is accepted unless reset is high or it targets a hardwired zero entry.
//
// Ports:
//   Clk, reset          : clock and synchronous active-high reset
//   we, wr_addr, wr_data: write port
//   ra_addr / ra_data   : read port A (combinational)
//   rb_addr / rb_data   : read port B (combinational)
//   wr_count            : saturating count of distinct entries written since reset
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int          DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int          ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter logic [63:0] RESET_VALUE = 64'd0,
  parameter int          ZERO_REG    = 0,
  parameter int          BYPASS      = 1
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] ra_addr,
  input  logic [ADDR_WIDTH-1:0] rb_addr,
  output logic [DATA_WIDTH-1:0] ra_data,
  output logic [DATA_WIDTH-1:0] rb_data,
  output logic [ADDR_WIDTH:0]   wr_count
);

  localparam int                     DEPTH   = depth_of(ADDR_WIDTH);
  localparam logic [DATA_WIDTH-1:0]  RST_VAL = DATA_WIDTH'(RESET_VALUE);
  localparam logic [ADDR_WIDTH:0]    CNT_MAX = (ADDR_WIDTH+1)'(DEPTH);
  localparam bit                     ZR_EN   = (ZERO_REG != 0);
  localparam bit                     BYP_EN  = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] entry_q [DEPTH];
  logic [DEPTH-1:0]      wr_sel;
  logic [DEPTH-1:0]      written_q;
  logic                  wr_ok;
  logic                  wr_new;

  // A write to the hardwired zero entry is not a write at all: no storage,
  // no written flag, no bypass.
  assign wr_ok = we && !(ZR_EN && (wr_addr == '0));

  always_comb begin
    wr_sel = '0;
    if (wr_ok) begin
      wr_sel[wr_addr] = 1'b1;
    end
  end

  // Storage: entry 0 collapses to a constant when it is hardwired to zero.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    if (ZR_EN && (i == 0)) begin : g_zero
      assign entry_q[i] = '0;
    end else begin : g_cell
      reg_cell #(
        .DATA_WIDTH (DATA_WIDTH)
      ) u_cell (
        .Clk     (Clk),
        .reset   (reset),
        .en      (wr_sel[i]),
        .rst_val (RST_VAL),
        .d       (wr_data),
        .q       (entry_q[i])
      );
    end
  end

  // First accepted write to an entry since reset bumps the count.
  assign wr_new = wr_ok && !written_q[wr_addr];

  always_ff @(posedge Clk) begin
    if (reset) begin
      written_q <= '0;
      wr_count  <= '0;
    end else begin
      written_q <= written_q | wr_sel;
      if (wr_new && (wr_count != CNT_MAX)) begin
        wr_count <= wr_count + 1'b1;
      end
    end
  end

  // Read muxes. Priority: zero entry > bypass > stored value.
  // Bypass is suppressed during reset since the write it would forward is dropped.
  always_comb begin
    ra_data = entry_q[ra_addr];
    if (BYP_EN && wr_ok && !reset && (ra_addr == wr_addr)) begin
      ra_data = wr_data;
    end
    if (ZR_EN && (ra_addr == '0)) begin
      ra_data = '0;
    end
  end

  always_comb begin
    rb_data = entry_q[rb_addr];
    if (BYP_EN && wr_ok && !reset && (rb_addr == wr_addr)) begin
      rb_data = wr_data;
    end
    if (ZR_EN && (rb_addr == '0)) begin
      rb_data = '0;
    end
  end

endmodule : regfile_2r1w

// File: tb/tb_regfile_2r1w.sv
// Purpose: self-checking bench for regfile_2r1w across three configurations.
// Latency: n/a.
// Backpressure: n/a.
module tb_regfile_2r1w;

  localparam int NCFG = 3;
  localparam logic [7:0] RV = 8'h5A;
  // Configurations: 0 = bypass, 1 = no bypass, 2 = zero reg + bypass.
  localparam bit CFG_ZR [NCFG] = '{1'b0, 1'b0, 1'b1};
  localparam bit CFG_BP [NCFG] = '{1'b1, 1'b0, 1'b1};

  logic       Clk = 1'b0;
  logic       reset, we;
  logic [2:0] wr_addr, ra_addr, rb_addr;
  logic [7:0] wr_data;
  logic [7:0] ra_o [NCFG];
  logic [7:0] rb_o [NCFG];
  logic [3:0] cnt_o [NCFG];

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  regfile_2r1w #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .RESET_VALUE(64'h5A), .ZERO_REG(0), .BYPASS(1)) dut_a (
    .Clk(Clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_o[0]), .rb_data(rb_o[0]), .wr_count(cnt_o[0]));
  regfile_2r1w #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .RESET_VALUE(64'h5A), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .Clk(Clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_o[1]), .rb_data(rb_o[1]), .wr_count(cnt_o[1]));
  regfile_2r1w #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .RESET_VALUE(64'h5A), .ZERO_REG(1), .BYPASS(1)) dut_z (
    .Clk(Clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_o[2]), .rb_data(rb_o[2]), .wr_count(cnt_o[2]));

  // Reference model: contents, set of written addresses, count of that set.
  logic [7:0] mem  [NCFG][8];
  bit         seen [NCFG][8];
  int         cnt  [NCFG];

  typedef struct {
    bit rst; bit w; logic [2:0] wa; logic [7:0] wd; logic [2:0] ra; logic [2:0] rb;
    logic [7:0] era; logic [7:0] erb; logic [3:0] ecnt;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_rd(input int c, input logic [2:0] a);
    if (CFG_ZR[c] && a == 3'd0) return 8'h00;
    if (CFG_BP[c] && we && !reset && a == wr_addr && !(CFG_ZR[c] && wr_addr == 3'd0)) return wr_data;
    return mem[c][a];
  endfunction

  task automatic drive(input bit r, input bit w, input logic [2:0] wa, input logic [7:0] wd,
                       input logic [2:0] ra, input logic [2:0] rb);
    reset = r; we = w; wr_addr = wa; wr_data = wd; ra_addr = ra; rb_addr = rb;
    #2;
  endtask

  task automatic check_model();
    for (int c = 0; c < NCFG; c++) begin
      check($sformatf("cfg%0d ra[%0d]", c, ra_addr), 32'(ra_o[c]), 32'(exp_rd(c, ra_addr)));
      check($sformatf("cfg%0d rb[%0d]", c, rb_addr), 32'(rb_o[c]), 32'(exp_rd(c, rb_addr)));
      check($sformatf("cfg%0d wr_count", c), 32'(cnt_o[c]), 32'(cnt[c]));
    end
  endtask

  task automatic clock_model();
    @(posedge Clk);
    for (int c = 0; c < NCFG; c++) begin
      if (reset) begin
        for (int i = 0; i < 8; i++) begin
          mem[c][i] = (CFG_ZR[c] && i == 0) ? 8'h00 : RV;
          seen[c][i] = 1'b0;
        end
        cnt[c] = 0;
      end else if (we && !(CFG_ZR[c] && wr_addr == 3'd0)) begin
        mem[c][wr_addr] = wr_data;
        if (!seen[c][wr_addr]) begin
          seen[c][wr_addr] = 1'b1;
          if (cnt[c] < 8) cnt[c]++;
        end
      end
    end
    #1;
  endtask

  task automatic step(input bit r, input bit w, input logic [2:0] wa, input logic [7:0] wd,
                      input logic [2:0] ra, input logic [2:0] rb);
    drive(r, w, wa, wd, ra, rb);
    check_model();
    clock_model();
  endtask

  initial begin
    // Expected values for the bypass configuration, derived by hand.
    vecs[0] = '{0, 0, 3'd0, 8'h00, 3'd0, 3'd7, 8'h5A, 8'h5A, 4'd0};
    vecs[1] = '{0, 1, 3'd3, 8'h11, 3'd3, 3'd5, 8'h11, 8'h5A, 4'd0};
    vecs[2] = '{0, 1, 3'd3, 8'h22, 3'd3, 3'd4, 8'h22, 8'h5A, 4'd1};
    vecs[3] = '{0, 1, 3'd5, 8'h33, 3'd0, 3'd5, 8'h5A, 8'h33, 4'd1};
    vecs[4] = '{0, 0, 3'd0, 8'h00, 3'd3, 3'd5, 8'h22, 8'h33, 4'd2};
    vecs[5] = '{0, 1, 3'd2, 8'hC3, 3'd2, 3'd3, 8'hC3, 8'h22, 4'd2};
    vecs[6] = '{0, 0, 3'd0, 8'h00, 3'd2, 3'd2, 8'hC3, 8'hC3, 4'd3};
    vecs[7] = '{1, 1, 3'd4, 8'h77, 3'd4, 3'd2, 8'h5A, 8'hC3, 4'd3};
    vecs[8] = '{0, 0, 3'd0, 8'h00, 3'd4, 3'd2, 8'h5A, 8'h5A, 4'd0};

    // Initial reset; the model takes its reset state on the same edges.
    @(negedge Clk);
    drive(1, 0, 0, 0, 0, 0);
    clock_model();
    clock_model();

    // Reset state on every address, both ports.
    for (int a = 0; a < 8; a++) step(0, 0, 0, 0, 3'(a), 3'(7 - a));

    // Table-driven vectors (plus model checks on all configurations).
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].rst, vecs[i].w, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb);
      check($sformatf("vec%0d ra", i), 32'(ra_o[0]), 32'(vecs[i].era));
      check($sformatf("vec%0d rb", i), 32'(rb_o[0]), 32'(vecs[i].erb));
      check($sformatf("vec%0d cnt", i), 32'(cnt_o[0]), 32'(vecs[i].ecnt));
      check_model();
      clock_model();
    end

    // No-bypass: same-cycle read of address being written returns old value.
    drive(0, 1, 3'd6, 8'hC3, 3'd6, 3'd6);
    check("nobyp old value", 32'(ra_o[1]), 32'h5A);
    check("byp new value", 32'(ra_o[0]), 32'hC3);
    clock_model();

    // Zero register: write FF to entry 0, including same-cycle read.
    step(1, 0, 0, 0, 0, 0);
    drive(0, 1, 3'd0, 8'hFF, 3'd0, 3'd0);
    check("zr bypass addr0", 32'(ra_o[2]), 32'h00);
    check("nzr bypass addr0", 32'(ra_o[0]), 32'hFF);
    clock_model();
    drive(0, 0, 0, 0, 3'd0, 3'd0);
    check("zr addr0 after write", 32'(rb_o[2]), 32'h00);
    check("zr cnt unchanged", 32'(cnt_o[2]), 32'd0);
    check("nzr cnt after addr0", 32'(cnt_o[0]), 32'd1);
    clock_model();

    // Saturation: write every address, rewrite addr 1.
    for (int a = 0; a < 8; a++) step(0, 1, 3'(a), 8'(8'h80 + a), 3'(a), 3'd1);
    step(0, 1, 3'd1, 8'hEE, 3'd1, 3'd0);
    drive(0, 0, 0, 0, 3'd1, 3'd7);
    check("sat cnt", 32'(cnt_o[0]), 32'd8);
    check("sat cnt zr", 32'(cnt_o[2]), 32'd7);
    check("rewrite addr1", 32'(ra_o[0]), 32'hEE);
    check_model();
    clock_model();

    // Reset together with a write to addr 4: write dropped.
    step(1, 1, 3'd4, 8'h44, 3'd4, 3'd4);
    drive(0, 0, 0, 0, 3'd4, 3'd1);
    check("rst drops write", 32'(ra_o[0]), 32'h5A);
    check("rst clears cnt", 32'(cnt_o[0]), 32'd0);
    clock_model();

    // Reset mid-stream between two writes.
    step(0, 1, 3'd6, 8'hA1, 3'd6, 3'd6);
    step(1, 0, 0, 0, 3'd6, 3'd1);
    step(0, 1, 3'd1, 8'hB2, 3'd1, 3'd6);
    for (int a = 0; a < 8; a++) begin
      drive(0, 0, 0, 0, 3'(a), 3'(a));
      check($sformatf("midrst addr%0d", a), 32'(ra_o[0]), (a == 1) ? 32'hB2 : 32'h5A);
      check_model();
      clock_model();
    end
    check("midrst cnt", 32'(cnt_o[0]), 32'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(31) == 0), $urandom_range(1) == 1, 3'($urandom_range(7)),
           8'($urandom), 3'($urandom_range(7)), 3'($urandom_range(7)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_regfile_2r1w

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised register file: 2^ADDR_WIDTH entries of DATA_WIDTH bits, one synchronous write port, two asynchronous read ports, and optional write-to-read bypass and hardwired-zero entry 0. It is the storage successor to the single enabled register with loadable reset value. It serves as the architectural register file for the lab datapath and CPU stages. All entries return to a common reset value on synchronous reset.

## Interface
Parameters:
- DATA_WIDTH, 8: bits per entry.
- ADDR_WIDTH, 3: address bits; depth = 2^ADDR_WIDTH.
- RESET_VALUE, 0: value loaded into every entry on reset. Truncated to DATA_WIDTH.
- ZERO_REG, 0: when 1, entry 0 always reads 0 and ignores writes.
- BYPASS, 1: when 1, a read of the address being written this cycle returns wr_data.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- reset  input  1  reset, synchronous, active-high; clock Clk.
- we  input  1  write enable.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- ra_addr  input  ADDR_WIDTH  read port A address.
- rb_addr  input  ADDR_WIDTH  read port B address.
- ra_data  output  DATA_WIDTH  read port A data (combinational).
- rb_data  output  DATA_WIDTH  read port B data (combinational).
- wr_count  output  ADDR_WIDTH+1  saturating count of distinct entries written since reset.

## Operation
- Reset (rising edge with reset=1): every entry <= RESET_VALUE. Entry 0 <= 0 if ZERO_REG=1. wr_count <= 0. A write in the same cycle is dropped; reset has priority.
- Write (reset=0, we=1): entry[wr_addr] <= wr_data at the edge. With ZERO_REG=1 and wr_addr=0, no state change.
- Write tracking: a per-entry written flag (depth bits) is cleared on reset and set on the first accepted write. wr_count increments only when the flag was clear. It saturates at depth.
- Read: ra_data = entry[ra_addr]. Same for port B. Both ports are independent, and both may use the same address.
- Bypass (BYPASS=1): if we=1, reset=0, and read addr == wr_addr (excluding a zeroed entry 0), the port outputs wr_data in the same cycle. With BYPASS=0, the port outputs the stored old value.
- ZERO_REG=1: reads of address 0 return 0 regardless of bypass.
- With reset=1, reads return stored contents. There is no bypass during reset.

## Timing
- Write latency: 1 cycle. Data is visible via the stored path on the cycle after the edge, and on the same cycle via bypass.
- Read latency: 0 cycles (combinational from address and storage).
- After reset is released: all reads return RESET_VALUE (0 for entry 0 if ZERO_REG), and wr_count=0.
- Reset asserted mid-stream: takes effect at the next edge. Writes on that edge are discarded.
- Back-to-back writes to the same address: the last one wins. wr_count increments once.

## Structure
- Shared package regfile_pkg: the default width and address constants, and a function computing depth from ADDR_WIDTH.
- Sub-module reg_cell: one DATA_WIDTH register with enable, synchronous reset, and a reset-value input. It is instantiated depth times in a generate loop. Entry 0 is replaced by constant 0 when ZERO_REG=1.
- Top level holds the written-flag vector, the wr_count logic, and the two read muxes with bypass compare.

## Test plan
- Reset, RESET_VALUE=8'h5A, defaults: release reset, read all 8 addresses on A and B -> all 8'h5A, wr_count=0.
- Write 8'h11 to addr 3, then 8'h22 to addr 3, then 8'h33 to addr 5. Read A=3, B=5 -> 8'h22 / 8'h33, wr_count=2.
- BYPASS=1: we=1, wr_addr=2, wr_data=8'hC3, ra_addr=2 in the same cycle -> ra_data=8'hC3 before the edge. Repeat with BYPASS=0 -> old value 8'h5A.
- ZERO_REG=1: write 8'hFF to addr 0 -> reads of addr 0 return 0 (including same-cycle bypass), and wr_count unchanged.
- Write all 8 addresses, then rewrite addr 1 -> wr_count saturates at 8. Assert reset together with a write to addr 4 -> addr 4 reads RESET_VALUE, wr_count=0.
- Reset mid-stream: assert reset for one cycle between two writes -> only the post-reset write is visible. All other entries read RESET_VALUE.
